// File: rtl/prescaler_pkg.sv
// prescaler_pkg: shared state encoding and default divisor width for the prescaler.
package prescaler_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;
  localparam int DIV_W_DEF = 8;
endpackage

// File: rtl/presc_counter.sv
// presc_counter: half-period counter that toggles clk_out at each terminal count.
module presc_counter import prescaler_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             terminal,
  output logic             clk_out
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  assign terminal = cnt_q == div - DIV_W'(1);
  assign clk_out  = clk_q;
  always_comb begin
    cnt_d = clear ? '0 : run ? (terminal ? '0 : cnt_q + DIV_W'(1)) : cnt_q;
    clk_d = clear ? 1'b0 : (run && terminal) ? !clk_q : clk_q;
  end
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end
endmodule

// File: rtl/prescaler_ctrl.sv
// prescaler_ctrl: run/stop FSM and glitch-free divisor update handshake around presc_counter.
module prescaler_ctrl import prescaler_pkg::*; #(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);
  state_e           state_q, state_d;
  logic             pend_q, pend_d, tick_q, tick_d, err_q, err_d;
  logic [DIV_W-1:0] active_q, active_d, shadow_q, shadow_d;
  logic             run, clear, terminal, accept, fall, apply;
  assign accept    = cfg_valid && !pend_q;
  assign fall      = run && terminal && clk_out;
  // A new divisor only lands when no half-period is in flight: idle, or a falling boundary.
  assign apply     = pend_q && (state_q == IDLE || fall);
  assign cfg_ready = !pend_q;
  assign cfg_err   = err_q;
  assign tick      = tick_q;
  assign busy      = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    unique case (state_q)
      IDLE: state_d = (en && !pend_q) ? RUN : IDLE;
      RUN: begin
        run     = en || clk_out;
        state_d = en ? RUN : (!clk_out || terminal) ? IDLE : STOP;
      end
      STOP: begin
        run     = 1'b1;
        state_d = en ? RUN : terminal ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
    clear    = !run;
    pend_d   = (accept && cfg_div != '0) ? 1'b1 : apply ? 1'b0 : pend_q;
    shadow_d = (accept && cfg_div != '0) ? cfg_div : shadow_q;
    active_d = apply ? shadow_q : active_q;
    tick_d   = run && terminal && !clk_out;
    err_d    = accept && cfg_div == '0;
  end
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
      active_q <= DIV_W'(DIV_RST);
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end
  presc_counter #(.DIV_W(DIV_W)) u_cnt (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .clear   (clear),
    .run     (run),
    .div     (active_q),
    .terminal(terminal),
    .clk_out (clk_out)
  );
endmodule

// File: tb/tb_prescaler_ctrl.sv
// tb_prescaler_ctrl: directed table, corner sequences and random run against a phase-level model.
module tb_prescaler_ctrl;
  logic       clk_in = 1'b0, reset_n = 1'b0, en = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready, cfg_err, clk_out, tick, busy;
  int         checks = 0, errors = 0;

  prescaler_ctrl #(.DIV_W(8), .DIV_RST(4)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // Model: mode 0 idle / 1 run / 2 stop, level of the output, edges left in the current half-period.
  int         m_mode, m_left;
  logic       m_lvl, m_tick, m_err, m_pend;
  logic [7:0] m_act, m_shadow;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_lvl = 0; m_tick = 0; m_err = 0; m_pend = 0; m_act = 8'd4; m_shadow = 8'd0;
  endtask

  task automatic model_edge(input logic e, input logic v, input logic [7:0] d);
    logic acc, fell;
    acc = v && !m_pend;
    m_err = acc && d == 8'd0;
    m_tick = 0;
    if (m_mode == 0) begin
      if (m_pend) begin m_act = m_shadow; m_pend = 0; end
      else if (e) begin m_mode = 1; m_left = m_act; end
    end else if (m_mode == 1 && !e && !m_lvl) begin
      m_mode = 0;
    end else begin
      fell = 0;
      m_left = m_left - 1;
      if (m_left == 0) begin
        fell = m_lvl;
        m_lvl = !m_lvl;
        m_tick = m_lvl;
        if (fell && m_pend) begin m_act = m_shadow; m_pend = 0; end
        m_left = m_act;
      end
      m_mode = e ? 1 : (fell ? 0 : 2);
    end
    if (acc && d != 8'd0) begin m_pend = 1; m_shadow = d; end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic v, input logic [7:0] d);
    en = e; cfg_valid = v; cfg_div = d;
    @(posedge clk_in);
    model_edge(e, v, d);
    #1;
    chk("m_clk_out", clk_out, m_lvl);
    chk("m_tick", tick, m_tick);
    chk("m_busy", busy, m_mode != 0);
    chk("m_cfg_ready", cfg_ready, !m_pend);
    chk("m_cfg_err", cfg_err, m_err);
  endtask

  typedef struct {
    logic e, v; logic [7:0] d;
    logic clk, tk, bsy, rdy, err;
  } vec_t;

  function automatic vec_t mk(logic e, logic v, logic [7:0] d, logic c, logic t, logic b, logic r, logic x);
    vec_t w;
    w.e = e; w.v = v; w.d = d; w.clk = c; w.tk = t; w.bsy = b; w.rdy = r; w.err = x;
    return w;
  endfunction

  initial begin
    vec_t tbl[22];
    int n;
    logic [7:0] want;
    logic hold;
    tbl[0]  = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tbl[4]  = mk(1, 0, 0, 1, 1, 1, 1, 0);
    tbl[5]  = mk(1, 1, 0, 1, 0, 1, 1, 1);
    tbl[6]  = mk(1, 0, 0, 1, 0, 1, 1, 0);
    tbl[7]  = mk(1, 0, 0, 1, 0, 1, 1, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tbl[9]  = mk(1, 1, 2, 0, 0, 1, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 1, 0, 0);
    tbl[12] = mk(1, 0, 0, 1, 1, 1, 0, 0);
    tbl[13] = mk(1, 0, 0, 1, 0, 1, 0, 0);
    tbl[14] = mk(1, 0, 0, 1, 0, 1, 0, 0);
    tbl[15] = mk(1, 0, 0, 1, 0, 1, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tbl[17] = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tbl[18] = mk(1, 0, 0, 1, 1, 1, 1, 0);
    tbl[19] = mk(1, 0, 0, 1, 0, 1, 1, 0);
    tbl[20] = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 1, 0);
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_cfg_err", cfg_err, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].e, tbl[i].v, tbl[i].d);
      chk($sformatf("row%0d_clk_out", i + 1), clk_out, tbl[i].clk);
      chk($sformatf("row%0d_tick", i + 1), tick, tbl[i].tk);
      chk($sformatf("row%0d_busy", i + 1), busy, tbl[i].bsy);
      chk($sformatf("row%0d_cfg_ready", i + 1), cfg_ready, tbl[i].rdy);
      chk($sformatf("row%0d_cfg_err", i + 1), cfg_err, tbl[i].err);
    end
    // Divisor is now 2: drop en in the high phase and let STOP finish it.
    n = 0;
    while (!clk_out && n < 20) begin step(1, 0, 0); n++; end
    chk("stop_rise_seen", clk_out, 1'b1);
    step(0, 0, 0);
    chk("stop_mid_high", clk_out, 1'b1);
    chk("stop_mid_busy", busy, 1'b1);
    step(0, 0, 0);
    chk("stop_fall", clk_out, 1'b0);
    chk("stop_idle_busy", busy, 1'b0);
    n = 0;
    while (!clk_out && n < 20) begin step(1, 0, 0); n++; end
    step(0, 0, 0);
    step(1, 0, 0);
    chk("resume_fall", clk_out, 1'b0);
    chk("resume_busy", busy, 1'b1);
    n = 0;
    while (!clk_out && n < 20) begin step(1, 0, 0); n++; end
    checks++;
    if (n != 2) begin errors++; $display("FAIL resume_low_len got %0d expected 2", n); end
    // Back-to-back held writes of 3 then 5.
    foreach (want[i]) want[i] = 1'b0;
    want = 8'd3;
    n = 0;
    while (n < 60) begin
      hold = m_pend;
      step(1, 1, want);
      n++;
      if (!hold) begin
        if (want == 8'd5) break;
        want = 8'd5;
      end
    end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL b2b_accept timed out after %0d cycles", n); end
    repeat (40) step(1, 0, 0);
    // Pending write, then asynchronous reset inside a high phase.
    step(1, 1, 8'd6);
    n = 0;
    while (!clk_out && n < 40) begin step(1, 0, 0); n++; end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_clk_out", clk_out, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cfg_ready", cfg_ready, 1'b1);
    model_reset();
    @(posedge clk_in);
    #1 reset_n = 1'b1;
    n = 0;
    while (!clk_out && n < 20) begin step(1, 0, 0); n++; end
    checks++;
    if (n != 5) begin errors++; $display("FAIL arst_rise_at got %0d expected 5", n); end
    // Random traffic; a held request keeps its data until it is accepted.
    hold = 1'b0;
    want = 8'd0;
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic e, v;
      e = ($urandom_range(0, 19) == 0) ? !en : en;
      if (hold && m_pend) v = 1'b1;
      else begin
        v = $urandom_range(0, 9) == 0;
        want = 8'($urandom_range(0, 6));
      end
      hold = v;
      step(e, v, want);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prescaler_ctrl.md
PRESCALER_CTRL -- requirements
Module: prescaler_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the half-period divisor.
REQ-002 SHALL have parameter DIV_RST, default 4, active divisor after reset (1..2^DIV_W-1).
REQ-003 SHALL have port clk_in  input  1  single clock, rising edge only.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  level; request to run the output clock.
REQ-006 SHALL have port cfg_valid  input  1  divisor update request.
REQ-007 SHALL have port cfg_div  input  DIV_W  requested half-period in clk_in cycles.
REQ-008 SHALL have port cfg_ready  output  1  update can be accepted.
REQ-009 SHALL have port cfg_err  output  1  one-cycle pulse: zero divisor rejected.
REQ-010 SHALL have port clk_out  output  1  divided clock, registered.
REQ-011 SHALL have port tick  output  1  one-cycle pulse coincident with clk_out rising.
REQ-012 SHALL have port busy  output  1  high in RUN or STOP.

Function
REQ-013 SHALL implement states IDLE, RUN, STOP.
REQ-014 IDLE: counter 0, clk_out 0; go to RUN when en=1 and no update pending.
REQ-015 RUN: counter increments each cycle; at counter==active_div-1 it clears and clk_out toggles; period = 2*active_div cycles, 50% duty.
REQ-016 RUN with en=0: if clk_out=0, go to IDLE next edge, counter cleared; if clk_out=1, go to STOP.
REQ-017 STOP: keep counting; at terminal count clk_out falls and state goes to IDLE; en=1 in STOP returns to RUN with no gap or phase change.
REQ-018 Handshake: transfer when cfg_valid && cfg_ready; data captured to shadow register, pending flag set.
REQ-019 cfg_ready = !pending; cfg_valid may be held, cfg_div stable while held.
REQ-020 cfg_div==0: transfer completes, cfg_err pulses next cycle, nothing becomes pending, active_div unchanged.
REQ-021 Pending applied in IDLE on the next edge; in RUN/STOP only at the terminal count where clk_out falls, and the counter clears there.
REQ-022 Never change active_div mid half-period; clk_out high/low phases always equal the divisor in force at the preceding falling boundary.
REQ-023 Update accepted on the same edge as a boundary is applied at the following boundary, not the current one.
REQ-024 IDLE with en=1 and pending: apply first, enter RUN one cycle later.
REQ-025 tick asserts for exactly the cycle in which clk_out is first 1.
REQ-026 Counter width DIV_W; compare against active_div-1, no wrap past it.

Reset
REQ-027 reset_n low: state IDLE, counter 0, clk_out 0, tick 0, cfg_err 0, busy 0, pending 0, active_div=DIV_RST, cfg_ready 1.
REQ-028 Reset mid-period SHALL force clk_out low immediately (asynchronous) and discard any pending update.
REQ-029 Deassertion SHALL be sampled on clk_in; first state change no earlier than the first edge after release.

Structure
REQ-030 Package prescaler_pkg SHALL hold the state enumeration and the DIV_W default.
REQ-031 Counter/toggle datapath SHALL be one sub-module presc_counter (inputs clear, run, div; outputs terminal, clk_out); FSM, shadow register and handshake remain in prescaler_ctrl.

Verification
REQ-032 Reset, en=1 at edge 0, DIV_RST=4 -> RUN at edge 1, clk_out rises with tick at edge 5, falls at edge 9, period 8.
REQ-033 Running div=4, write cfg_div=2 mid high phase -> cfg_ready low until next falling boundary; following phases 2 cycles high/2 low.
REQ-034 en dropped while clk_out=1 -> STOP, full high phase completed, clk_out low, IDLE, busy low; en re-raised in STOP -> period unbroken.
REQ-035 cfg_div=0 -> one-cycle cfg_err, active divisor unchanged, cfg_ready stays high.
REQ-036 reset_n pulsed low mid high phase -> clk_out 0 asynchronously, pending cleared, active_div=4 after release.
REQ-037 Back-to-back cfg_valid held high with 3 then 5 -> second accepted only after first applied; phases 3 then 5.
